// File: rtl/bus_demux3_if.sv
// Master-side request/response bus of the 1-to-3 data-bus demux.
// The CPU load/store unit drives the master modport; the demux sits on the slave modport.
interface bus_demux3_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/bus_demux3.sv
// 1-to-3 data-bus demux: decodes the top 4 address bits, forwards one outstanding request
// to slave 0/1/2 and returns a single registered response pulse, with timeout and decode-error abort.
module bus_demux3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_demux3_if.slave           m_bus,
  output logic [2:0]            o_s_req,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_wdata,
  input  logic [2:0]            i_s_gnt,
  input  logic [2:0]            i_s_rvalid,
  input  logic [DATA_WIDTH-1:0] i_s_rdata0,
  input  logic [DATA_WIDTH-1:0] i_s_rdata1,
  input  logic [DATA_WIDTH-1:0] i_s_rdata2
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TMR_ZERO  = TW'(0);
  localparam logic [TW-1:0]         TMR_ONE   = TW'(1);
  localparam logic [TW-1:0]         TMR_LAST  = TW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_ERR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_rvalid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [2:0]            r_s_req;
  logic                  r_s_we;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wdata;
  logic [1:0]            r_sel;
  logic [TW-1:0]         r_timer;

  logic                  w_mapped;
  logic [1:0]            w_dec_sel;
  logic [2:0]            w_dec_oh;
  logic                  w_gnt;
  logic                  w_rvalid;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_resp_data;
  logic                  w_last;

  // Region decode of the incoming request address.
  always_comb begin
    w_mapped  = 1'b1;
    w_dec_sel = 2'd0;
    w_dec_oh  = 3'b000;
    case (m_bus.addr[ADDR_WIDTH-1 -: 4])
      4'h0: begin
        w_dec_sel = 2'd0;
        w_dec_oh  = 3'b001;
      end
      4'h1: begin
        w_dec_sel = 2'd1;
        w_dec_oh  = 3'b010;
      end
      4'h2: begin
        w_dec_sel = 2'd2;
        w_dec_oh  = 3'b100;
      end
      default: begin
        w_mapped  = 1'b0;
        w_dec_sel = 2'd0;
        w_dec_oh  = 3'b000;
      end
    endcase
  end

  // Only the captured slave's grant/response/data are visible to the FSM.
  always_comb begin
    w_gnt    = 1'b0;
    w_rvalid = 1'b0;
    w_rdata  = DATA_ZERO;
    case (r_sel)
      2'd0: begin
        w_gnt    = i_s_gnt[0];
        w_rvalid = i_s_rvalid[0];
        w_rdata  = i_s_rdata0;
      end
      2'd1: begin
        w_gnt    = i_s_gnt[1];
        w_rvalid = i_s_rvalid[1];
        w_rdata  = i_s_rdata1;
      end
      2'd2: begin
        w_gnt    = i_s_gnt[2];
        w_rvalid = i_s_rvalid[2];
        w_rdata  = i_s_rdata2;
      end
      default: begin
        w_gnt    = 1'b0;
        w_rvalid = 1'b0;
        w_rdata  = DATA_ZERO;
      end
    endcase
  end

  // Writes return zero data; reads return the selected slave's data.
  always_comb begin
    w_resp_data = DATA_ZERO;
    if (r_s_we) begin
      w_resp_data = DATA_ZERO;
    end else begin
      w_resp_data = w_rdata;
    end
  end

  assign w_last = (r_timer == TMR_LAST);

  // Transaction FSM; all outputs registered, response fields default to zero outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b1;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= DATA_ZERO;
      r_s_req   <= 3'b000;
      r_s_we    <= 1'b0;
      r_s_addr  <= ADDR_ZERO;
      r_s_wdata <= DATA_ZERO;
      r_sel     <= 2'd0;
      r_timer   <= TMR_ZERO;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= DATA_ZERO;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (m_bus.req) begin
            r_ready   <= 1'b0;
            r_timer   <= TMR_ZERO;
            r_s_we    <= m_bus.we;
            r_s_addr  <= m_bus.addr;
            r_s_wdata <= m_bus.wdata;
            r_sel     <= w_dec_sel;
            if (w_mapped) begin
              r_s_req <= w_dec_oh;
              r_state <= ST_REQ;
            end else begin
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_state  <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          r_timer <= r_timer + TMR_ONE;
          // A response arriving with the grant, even on the last allowed cycle, beats the timeout.
          if (w_gnt && w_rvalid) begin
            r_s_req  <= 3'b000;
            r_rvalid <= 1'b1;
            r_rdata  <= w_resp_data;
            r_state  <= ST_DONE;
          end else if (w_last) begin
            r_s_req  <= 3'b000;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_ERR;
          end else if (w_gnt) begin
            r_s_req <= 3'b000;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_timer <= r_timer + TMR_ONE;
          if (w_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_resp_data;
            r_state  <= ST_DONE;
          end else if (w_last) begin
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_ERR;
          end
        end
        ST_ERR, ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_s_req <= 3'b000;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_bus.ready  = r_ready;
  assign m_bus.rvalid = r_rvalid;
  assign m_bus.err    = r_err;
  assign m_bus.rdata  = r_rdata;
  assign o_s_req      = r_s_req;
  assign o_s_we       = r_s_we;
  assign o_s_addr     = r_s_addr;
  assign o_s_wdata    = r_s_wdata;
endmodule
